// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver on the 16x oversampling clock mclk16.
// It majority-votes three mid-bit samples per bit and presents each byte with a rxrdy/read handshake.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 mclk16,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 read,
    output logic [DATA_BITS-1:0] data,
    output logic                 rxrdy,
    output logic                 framing_err,
    output logic                 overrun_err
);

    localparam int BW = $clog2(DATA_BITS + 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   sync1_r;
    logic                   rx_s;
    logic [3:0]             cnt_r;
    logic [BW-1:0]          bitn_r;
    logic                   samp7_r;
    logic                   samp8_r;
    logic [DATA_BITS-1:0]   shreg_r;
    logic                   decide_s;
    logic                   wrap_s;
    logic                   bit_s;
    logic                   done_s;
    logic                   clear_cnt_s;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // cnt names the tick that starts at an edge, so the cnt=9 decision lands on the edge where cnt_r is 8.
    always_comb begin
        decide_s    = (cnt_r == 4'd8);
        wrap_s      = (cnt_r == 4'd15);
        bit_s       = maj3(samp7_r, samp8_r, rx_s);
        done_s      = (state_r == STOP) && decide_s;
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (decide_s && bit_s) begin
                    state_nxt_s = IDLE;
                end else if (wrap_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (wrap_s && (bitn_r == BW'(DATA_BITS))) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            STOP: begin
                if (decide_s) begin
                    if (bit_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_HIGH;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_HIGH;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        clear_cnt_s = (state_r == IDLE) || (state_nxt_s == IDLE) || (state_nxt_s == WAIT_HIGH);
    end

    // FSM state register.
    always_ff @(posedge mclk16 or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge mclk16 or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync1_r <= rx;
            rx_s    <= sync1_r;
        end
    end

    // Tick and bit counters run only inside a frame; start detection reloads them.
    always_ff @(posedge mclk16 or negedge reset) begin
        if (!reset) begin
            cnt_r  <= 4'd0;
            bitn_r <= {BW{1'b0}};
        end else if (clear_cnt_s) begin
            cnt_r  <= 4'd0;
            bitn_r <= {BW{1'b0}};
        end else begin
            cnt_r <= cnt_r + 4'd1;
            if (wrap_s) begin
                bitn_r <= bitn_r + BW'(1);
            end
        end
    end

    // Mid-bit samples and LSB-first shift register.
    always_ff @(posedge mclk16 or negedge reset) begin
        if (!reset) begin
            samp7_r <= 1'b0;
            samp8_r <= 1'b0;
            shreg_r <= {DATA_BITS{1'b0}};
        end else begin
            if (cnt_r == 4'd6) begin
                samp7_r <= rx_s;
            end
            if (cnt_r == 4'd7) begin
                samp8_r <= rx_s;
            end
            if ((state_r == DATA) && decide_s) begin
                shreg_r <= {bit_s, shreg_r[DATA_BITS-1:1]};
            end
        end
    end

    // Output register and handshake; a completing frame wins over a simultaneous read.
    always_ff @(posedge mclk16 or negedge reset) begin
        if (!reset) begin
            data        <= {DATA_BITS{1'b0}};
            rxrdy       <= 1'b0;
            framing_err <= 1'b0;
            overrun_err <= 1'b0;
        end else if (done_s) begin
            data        <= shreg_r;
            rxrdy       <= 1'b1;
            framing_err <= ~bit_s;
            if (rxrdy) begin
                overrun_err <= ~read;
            end
        end else if (read && rxrdy) begin
            rxrdy       <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// checked against a transaction-level model of the receiver's output registers.
module tb_uart_rx;

    logic       mclk16;
    logic       reset;
    logic       rx;
    logic       read;
    logic [7:0] data;
    logic       rxrdy;
    logic       framing_err;
    logic       overrun_err;

    int n_vec = 0;
    int n_err = 0;

    // Transaction-level expectations.
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_fe;
    logic       exp_ovr;

    uart_rx #(.DATA_BITS(8)) dut (
        .mclk16      (mclk16),
        .reset       (reset),
        .rx          (rx),
        .read        (read),
        .data        (data),
        .rxrdy       (rxrdy),
        .framing_err (framing_err),
        .overrun_err (overrun_err)
    );

    initial mclk16 = 1'b0;
    always #20 mclk16 = ~mclk16;

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_val({tag, ".data"}, {24'd0, data}, {24'd0, exp_data});
        check_val({tag, ".rxrdy"}, {31'd0, rxrdy}, {31'd0, exp_rdy});
        check_val({tag, ".framing_err"}, {31'd0, framing_err}, {31'd0, exp_fe});
        check_val({tag, ".overrun_err"}, {31'd0, overrun_err}, {31'd0, exp_ovr});
    endtask

    task automatic mdl_reset();
        exp_data = 8'h00;
        exp_rdy  = 1'b0;
        exp_fe   = 1'b0;
        exp_ovr  = 1'b0;
    endtask

    task automatic mdl_read();
        if (exp_rdy) begin
            exp_rdy = 1'b0;
            exp_ovr = 1'b0;
        end
    endtask

    task automatic mdl_frame(input logic [7:0] b, input logic stop, input logic rd_at_done);
        if (exp_rdy) begin
            exp_ovr = !rd_at_done;
        end
        exp_data = b;
        exp_rdy  = 1'b1;
        exp_fe   = !stop;
    endtask

    // Called at a negedge; returns at a negedge. A zero stop bit leaves the line low.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (16) @(negedge mclk16);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge mclk16);
        end
        rx = stop;
        repeat (16) @(negedge mclk16);
        rx = stop;
    endtask

    task automatic pulse_read();
        read = 1'b1;
        @(negedge mclk16);
        read = 1'b0;
    endtask

    // Read pulse landing on the completion edge (155th edge after the first edge that sees rx low).
    task automatic send_with_collision(input logic [7:0] b, input logic stop);
        fork
            send_frame(b, stop);
            begin
                repeat (155) @(posedge mclk16);
                @(negedge mclk16);
                read = 1'b1;
                @(negedge mclk16);
                read = 1'b0;
            end
        join
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge mclk16);
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         act;

        reset = 1'b0;
        rx    = 1'b1;
        read  = 1'b0;
        mdl_reset();
        repeat (5) @(negedge mclk16);
        check_all("reset_held");
        reset = 1'b1;
        @(negedge mclk16);
        check_all("reset_release");
        idle(500);
        check_all("reset_idle500");

        // Basic frame with exact latency of rxrdy.
        fork
            send_frame(8'hAF, 1'b1);
            begin
                repeat (155) @(posedge mclk16);
                #1 check_val("basic.rdy_before", {31'd0, rxrdy}, 32'd0);
                @(posedge mclk16);
                #1 check_val("basic.rdy_at_155", {31'd0, rxrdy}, 32'd1);
            end
        join
        mdl_frame(8'hAF, 1'b1, 1'b0);
        check_all("basic");
        pulse_read();
        mdl_read();
        check_all("basic.read");
        idle(10);
        pulse_read();
        check_all("basic.read_ignored");

        // False start: 6-cycle glitch, then a real frame.
        rx = 1'b0;
        repeat (6) @(negedge mclk16);
        idle(40);
        check_all("glitch");
        send_frame(8'h55, 1'b1);
        mdl_frame(8'h55, 1'b1, 1'b0);
        check_all("after_glitch");
        pulse_read();
        mdl_read();

        // Framing error followed by a long break.
        idle(5);
        send_frame(8'h3C, 1'b0);
        mdl_frame(8'h3C, 1'b0, 1'b0);
        check_all("ferr");
        repeat (200) @(negedge mclk16);
        check_all("break_end");
        idle(20);
        pulse_read();
        mdl_read();
        send_frame(8'h81, 1'b1);
        mdl_frame(8'h81, 1'b1, 1'b0);
        check_all("after_break");

        // Overrun, then read clears it.
        pulse_read();
        mdl_read();
        idle(3);
        send_frame(8'h12, 1'b1);
        mdl_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1);
        mdl_frame(8'h34, 1'b1, 1'b0);
        check_all("overrun");
        pulse_read();
        mdl_read();
        check_all("overrun.read");

        // Read coinciding with completion: completion wins, overrun clears.
        idle(3);
        send_frame(8'h12, 1'b1);
        mdl_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1);
        mdl_frame(8'h12, 1'b1, 1'b0);
        check_all("collision.pre");
        send_with_collision(8'h34, 1'b1);
        mdl_frame(8'h34, 1'b1, 1'b1);
        check_all("collision");

        // Reset in the middle of data bit 4.
        idle(4);
        fork
            send_frame(8'hE7, 1'b1);
            begin
                repeat (16 * 4 + 8) @(negedge mclk16);
                #5 reset = 1'b0;
                #1 mdl_reset();
                check_all("midreset.async");
            end
        join
        idle(4);
        reset = 1'b1;
        idle(4);
        check_all("midreset.release");
        send_frame(8'hC3, 1'b1);
        mdl_frame(8'hC3, 1'b1, 1'b0);
        check_all("midreset.next");

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            act  = $urandom_range(0, 2);
            if (act == 1) begin
                pulse_read();
                mdl_read();
                check_val("rnd.read_rdy", {31'd0, rxrdy}, {31'd0, exp_rdy});
            end
            if (act == 2) begin
                send_with_collision(b, stop);
                mdl_frame(b, stop, 1'b1);
            end else begin
                send_frame(b, stop);
                mdl_frame(b, stop, 1'b0);
            end
            if (!stop) begin
                repeat ($urandom_range(10, 60)) @(negedge mclk16);
            end
            check_all($sformatf("rnd%0d", i));
            idle($urandom_range(2, 20));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the UART: the receive-side counterpart of the `uart` transmitter. It runs on the same 16× oversampling clock `mclk16`, recovers 8N1 frames (1 start, 8 data LSB first, 1 stop) from the `rx` line, and presents each byte with a ready/read handshake. Framing and overrun status are flagged per byte. The bit period is fixed at 16 `mclk16` cycles.

## Interface
- `DATA_BITS`, default 8: data bits per frame. The 8N1 behaviour below uses 8. The `data` width follows this parameter.
- `mclk16`  in  1  16× baud clock; rising edge active.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; idles high; asynchronous to `mclk16`.
- `read`  in  1  consumer acknowledge, one cycle; effective only while `rxrdy`=1.
- `data`  out  DATA_BITS  last received byte; held until the next frame completes.
- `rxrdy`  out  1  unread byte available.
- `framing_err`  out  1  stop bit of the byte in `data` was sampled 0.
- `overrun_err`  out  1  sticky: a byte was overwritten before being read.

## Operation
- **Synchronizer:** 2-flop synchronizer on `rx`; both flops reset to 1. The synchronized signal is `rx_s`.
- **Counters:**
  - `cnt` is a 4-bit tick counter, 0..15, wrapping 15→0.
  - `bitn` is the bit index: 0 = start, 1..8 = data, 9 = stop. It increments on each `cnt` wrap.
- **States:** IDLE, START, DATA, STOP, WAIT_HIGH.
- **IDLE:**
  - `rx_s`=0 → START, with `cnt`←0 and `bitn`←0.
  - Otherwise stay in IDLE.
- **Sampling, every bit:**
  - Capture `rx_s` at `cnt`=7 and `cnt`=8.
  - The bit value is the majority of {sample7, sample8, `rx_s` at `cnt`=9}, decided on the `cnt`=9 edge.
- **START:** on decision:
  - Value 0 → continue, entering DATA at the wrap.
  - Value 1 → false start; go to IDLE immediately on the `cnt`=9 edge.
- **DATA:**
  - Each decision shifts the bit into the shift register LSB-first, at position `bitn`-1.
  - After bit 8 wraps → STOP.
- **STOP, decision at `cnt`=9:**
  - `data`←shift register.
  - `rxrdy`←1.
  - `framing_err`←(value==0).
  - Stop=1 → IDLE, re-armed mid-stop-bit for resync.
  - Stop=0 → WAIT_HIGH.
- **WAIT_HIGH:** stay until `rx_s`=1, then IDLE. This handles break: one byte is reported and no spurious frames follow.
- **Handshake:**
  - `read`=1 with `rxrdy`=1 → `rxrdy`←0 and `overrun_err`←0 on the next edge.
  - `read` with `rxrdy`=0 is ignored.
  - `data` and `framing_err` are not cleared by `read`.
- **Overrun:** frame completion while `rxrdy`=1 and `read`=0:
  - `data` is overwritten.
  - `overrun_err`←1.
  - `rxrdy` stays 1.
- **Simultaneous completion and `read`:**
  - Completion wins: `rxrdy` stays 1 and the new byte is loaded.
  - `overrun_err`←0; it is not set.
- **Reset (any time, including mid-frame):**
  - FSM→IDLE.
  - `cnt`=0, `bitn`=0, shift register=0.
  - `data`=0, `rxrdy`=0, `framing_err`=0, `overrun_err`=0.

## Timing
- Reset values: `data`=0, `rxrdy`=0, `framing_err`=0, `overrun_err`=0. Outputs clear asynchronously on `reset` falling.
- Synchronizer latency is 2 edges. If `rx` falls before edge Ef, IDLE sees `rx_s`=0 at edge E0=Ef+2.
- Relative to E0, bit k is decided at edge E0+16k+9:
  - Start bit at E0+9.
  - Stop bit at E0+153.
- `data`, `rxrdy` and `framing_err` are valid after edge E0+153, i.e. Ef+155.
- `read` sampled at edge N → `rxrdy`=0 after edge N. This is a 1-cycle response.
- Earliest next start detection:
  - After a good stop: edge E0+154.
  - After a framing error: 1 cycle after `rx_s` returns high.
- Tolerated baud mismatch is about ±3% (mid-bit sampling over 10 bits).
- With the 40 ns `mclk16` used in simulation, a bit is 640 ns and a frame is 6.4 µs.

## Test plan
- **Reset:** hold `reset`=0 with `rx`=1, then release. → `data`=0x00, `rxrdy`=0, both error flags 0; still all 0 after 500 idle cycles.
- **Basic frame:** send 0xAF (line sequence 0,1,1,1,1,0,1,0,1,1). → `rxrdy` rises exactly 155 edges after the `rx` fall, `data`=0xAF, `framing_err`=0. Pulse `read` → `rxrdy`=0 one cycle later.
- **False start:** glitch `rx` low for 6 cycles, then send 0x55. → no `rxrdy` from the glitch; `data`=0x55 and `rxrdy`=1 after the real frame.
- **Framing error and break:** send 0x3C with stop=0 and hold `rx` low 200 cycles, then high, then send 0x81.
  - → After the first frame: `data`=0x3C, `framing_err`=1, `rxrdy`=1, and no further frame during the low time.
  - → After the second frame: `data`=0x81, `framing_err`=0.
- **Overrun and read collision:**
  - Send 0x12 then 0x34 back-to-back with no `read`. → `data`=0x34, `rxrdy`=1, `overrun_err`=1. A `read` then clears `rxrdy` and `overrun_err`.
  - Repeat with `read` coinciding with the second frame's completion edge. → `rxrdy`=1, `data`=0x34, `overrun_err`=0.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0xE7, release, then send 0xC3. → outputs zero immediately on assertion; `data`=0xC3 afterward with no residual bits.
